// File: rtl/bp_be_pkg.sv
// Shared backend FP types: operation/precision/rounding enums, exception
// flags, and the request/response records of the aux-FPU arbiter.
package bp_be_pkg;

  // Struct field widths; the arbiter's default parameters match these.
  localparam int tag_width_gp    = 5;
  localparam int req_id_width_gp = 1;

  typedef enum logic [3:0] {
    e_op_fadd   = 4'd0,
    e_op_fsub   = 4'd1,
    e_op_fmul   = 4'd2,
    e_op_fmin   = 4'd3,
    e_op_fmax   = 4'd4,
    e_op_fsgnj  = 4'd5,
    e_op_fsgnjn = 4'd6,
    e_op_fsgnjx = 4'd7,
    e_op_feq    = 4'd8,
    e_op_flt    = 4'd9,
    e_op_fle    = 4'd10,
    e_op_fclass = 4'd11,
    e_op_f2i    = 4'd12,
    e_op_i2f    = 4'd13
  } bp_be_fp_fu_op_e;

  typedef enum logic {
    e_pr_single = 1'b0,
    e_pr_double = 1'b1
  } bp_be_fp_pr_e;

  typedef enum logic [2:0] {
    e_rne = 3'd0,
    e_rtz = 3'd1,
    e_rdn = 3'd2,
    e_rup = 3'd3,
    e_rmm = 3'd4,
    e_dyn = 3'd7
  } rv64_frm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

  typedef struct packed {
    bp_be_fp_fu_op_e             op;
    bp_be_fp_pr_e                ipr;
    bp_be_fp_pr_e                opr;
    rv64_frm_e                   rm;
    logic [63:0]                 a;
    logic [63:0]                 b;
    logic [tag_width_gp-1:0]     tag;
  } bp_be_fp_aux_req_s;

  typedef struct packed {
    logic [63:0]                 result;
    rv64_fflags_s                eflags;
    logic [tag_width_gp-1:0]     tag;
    logic [req_id_width_gp-1:0]  req_id;
  } bp_be_fp_aux_resp_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular result buffer. Enqueue and dequeue may happen in the same
// cycle at any occupancy; ready_o reports room, counting a same-cycle dequeue.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [width_p-1:0]           data_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr;
  logic [ptr_width_lp-1:0] rptr;
  logic [cnt_width_lp-1:0] count;

  function automatic logic [ptr_width_lp-1:0] bump(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (v_i)    wptr <= bump(wptr);
      if (yumi_i) rptr <= bump(rptr);
      if (v_i && !yumi_i)      count <= count + cnt_width_lp'(1);
      else if (!v_i && yumi_i) count <= count - cnt_width_lp'(1);
    end
  end

  // Storage write; the head is read combinationally before the edge, so a
  // write into the slot being dequeued at full occupancy is safe.
  always_ff @(posedge clk_i) begin
    if (v_i) mem[wptr] <= data_i;
  end

  assign v_o     = (count != '0);
  assign data_o  = mem[rptr];
  assign ready_o = (count != cnt_width_lp'(els_p)) || yumi_i;
  assign count_o = count;

endmodule

// File: rtl/bp_be_fp_aux_arbiter.sv
// Round-robin arbiter in front of a fixed-latency auxiliary FPU. Launches are
// credit-gated against the result FIFO so a returning result always has room.
// Handshake: a request transfers on req_v_i[k] & req_ready_o[k]; a result
// leaves on v_o & yumi_i, and yumi_i is only legal while v_o is high.
module bp_be_fp_aux_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int fpu_latency_p = 1,
  parameter int fifo_els_p    = 4,
  parameter int tag_width_p   = tag_width_gp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 flush_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  output logic [num_req_p-1:0]                 req_ready_o,
  input  bp_be_fp_aux_req_s [num_req_p-1:0]    req_i,
  output bp_be_fp_fu_op_e                      fpu_op_o,
  output bp_be_fp_pr_e                         fpu_ipr_o,
  output bp_be_fp_pr_e                         fpu_opr_o,
  output rv64_frm_e                            fpu_rm_o,
  output logic [63:0]                          fpu_a_o,
  output logic [63:0]                          fpu_b_o,
  input  logic [63:0]                          fpu_result_i,
  input  rv64_fflags_s                         fpu_eflags_i,
  output logic                                 v_o,
  output bp_be_fp_aux_resp_s                   data_o,
  input  logic                                 yumi_i
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);

  logic [id_width_lp-1:0]  rr_ptr;
  logic [id_width_lp-1:0]  grant_id;
  logic [id_width_lp-1:0]  scan_id;
  logic                    grant_v;
  logic                    credit_ok;
  logic                    launch;
  bp_be_fp_aux_req_s       grant_req;

  logic [fpu_latency_p-1:0]                    trk_v;
  logic [fpu_latency_p-1:0][tag_width_p-1:0]   trk_tag;
  logic [fpu_latency_p-1:0][id_width_lp-1:0]   trk_id;

  logic                    enq_v;
  bp_be_fp_aux_resp_s      enq_data;
  logic                    fifo_reset;
  logic                    fifo_ready;
  logic                    fifo_v;
  logic                    fifo_yumi;
  logic [cnt_width_lp-1:0] fifo_count;

  // Round-robin pick: lowest valid index at or after the pointer, wrapping.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    scan_id  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      scan_id = id_width_lp'((int'(rr_ptr) + i) % num_req_p);
      if (!grant_v && req_v_i[scan_id]) begin
        grant_v  = 1'b1;
        grant_id = scan_id;
      end
    end
  end

  // Everything counted here (buffered plus in flight) will need a FIFO slot.
  assign credit_ok = (int'(fifo_count) + $countones(trk_v) + 1) <= fifo_els_p;
  assign launch    = grant_v && credit_ok && reset_n_i && !flush_i;
  assign grant_req = req_i[grant_id];

  // One-hot ready to the winner, only when a launch actually happens.
  always_comb begin
    req_ready_o = '0;
    if (launch) req_ready_o[grant_id] = 1'b1;
  end

  // Operand drive: granted fields on a launch, a harmless fsgnj of zeros otherwise.
  always_comb begin
    fpu_op_o  = e_op_fsgnj;
    fpu_ipr_o = e_pr_single;
    fpu_opr_o = e_pr_single;
    fpu_rm_o  = e_rne;
    fpu_a_o   = '0;
    fpu_b_o   = '0;
    if (launch) begin
      fpu_op_o  = grant_req.op;
      fpu_ipr_o = grant_req.ipr;
      fpu_opr_o = grant_req.opr;
      fpu_rm_o  = grant_req.rm;
      fpu_a_o   = grant_req.a;
      fpu_b_o   = grant_req.b;
    end
  end

  // Pointer moves past the winner only when a request transfers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  rr_ptr <= '0;
    else if (launch) rr_ptr <= id_width_lp'((int'(grant_id) + 1) % num_req_p);
  end

  // Tracker valid bits; flush and reset both drop every in-flight op.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || flush_i) begin
      trk_v <= '0;
    end else begin
      trk_v[0] <= launch;
      for (int i = 1; i < fpu_latency_p; i++) trk_v[i] <= trk_v[i-1];
    end
  end

  // Tracker payload shifts alongside the valids; only meaningful where valid.
  always_ff @(posedge clk_i) begin
    trk_tag[0] <= tag_width_p'(grant_req.tag);
    trk_id[0]  <= grant_id;
    for (int i = 1; i < fpu_latency_p; i++) begin
      trk_tag[i] <= trk_tag[i-1];
      trk_id[i]  <= trk_id[i-1];
    end
  end

  // The last tracker stage lines up with the FPU result for that launch.
  assign enq_v           = trk_v[fpu_latency_p-1] && reset_n_i && !flush_i;
  assign enq_data.result = fpu_result_i;
  assign enq_data.eflags = fpu_eflags_i;
  assign enq_data.tag    = tag_width_gp'(trk_tag[fpu_latency_p-1]);
  assign enq_data.req_id = req_id_width_gp'(trk_id[fpu_latency_p-1]);

  // Flush empties the buffer the same way reset does.
  assign fifo_reset = !reset_n_i || flush_i;
  assign fifo_yumi  = yumi_i && fifo_v;

  bsg_fifo_1r1w_small #(
    .width_p ($bits(bp_be_fp_aux_resp_s)),
    .els_p   (fifo_els_p)
  ) result_fifo (
    .clk_i   (clk_i),
    .reset_i (fifo_reset),
    .v_i     (enq_v),
    .ready_o (fifo_ready),
    .data_i  (enq_data),
    .v_o     (fifo_v),
    .data_o  (data_o),
    .yumi_i  (fifo_yumi),
    .count_o (fifo_count)
  );

  assign v_o = fifo_v && reset_n_i;

  // Consumer must not dequeue an empty buffer.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  // Credit accounting must never let a result arrive at a full buffer.
  assert property (@(posedge clk_i) disable iff (!reset_n_i || flush_i) enq_v |-> fifo_ready);

endmodule
